// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: Moore state outputs plus ALU/branch decode, 3-5 cycles per instruction.
// Memory states stall on mem_ready (when MEM_HANDSHAKE=1) and abort to FETCH with bus_err after WAIT_MAX waits.
module multicycle_control_unit #(
  parameter int ALU_CTRL_W    = 3,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int WAIT_MAX      = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  Zero,
  input  logic                  SignFlag,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  IRWrite,
  output logic                  MemWrite,
  output logic                  RegWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ImmSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  illegal_op,
  output logic                  bus_err,
  output logic [3:0]            state
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              w_mem_state;
  logic              w_complete;
  logic              w_timeout;
  logic              w_is_sw;
  logic              w_take;
  logic              w_bad_br;
  logic [2:0]        w_alu_dec;
  logic [2:0]        w_alu_sel;
  logic              w_pcw;
  logic              w_irw;
  logic              w_mw;
  logic              w_rw;

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
  assign w_complete  = !MEM_HANDSHAKE || mem_ready;
  assign w_timeout   = w_mem_state && !w_complete && (r_wait == WAIT_W'(WAIT_MAX));
  assign w_is_sw     = (op == 7'b0100011);
  assign w_wait_nxt  = (w_mem_state && !w_complete && !w_timeout) ? r_wait + WAIT_W'(1) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_nxt;
    end
  end

  always_comb begin
    w_alu_dec = 3'b000;
    case (funct3)
      3'b000:  w_alu_dec = (op[5] && funct7b5) ? 3'b010 : 3'b000;
      3'b001:  w_alu_dec = 3'b001;
      3'b100:  w_alu_dec = 3'b100;
      3'b101:  w_alu_dec = funct7b5 ? 3'b011 : 3'b101;
      3'b110:  w_alu_dec = 3'b110;
      3'b111:  w_alu_dec = 3'b111;
      default: w_alu_dec = 3'b000;
    endcase
  end

  always_comb begin
    w_take   = 1'b0;
    w_bad_br = 1'b0;
    case (funct3)
      3'b000:  w_take = Zero;
      3'b001:  w_take = ~Zero;
      3'b100:  w_take = SignFlag;
      3'b101:  w_take = ~SignFlag;
      default: w_bad_br = 1'b1;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    w_pcw      = 1'b0;
    w_irw      = 1'b0;
    w_mw       = 1'b0;
    w_rw       = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ImmSrc     = 2'b00;
    w_alu_sel  = 3'b000;
    illegal_op = 1'b0;
    bus_err    = w_timeout;
    case (r_state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        w_irw     = w_complete;
        w_pcw     = w_complete;
        w_next    = w_complete ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b10;
        case (op)
          7'b0000011, 7'b0100011: w_next = S_MEMADR;
          7'b0110011:             w_next = S_EXECR;
          7'b0010011:             w_next = S_EXECI;
          7'b1100011:             w_next = S_BRANCH;
          7'b1101111:             w_next = S_JAL;
          default: begin
            illegal_op = 1'b1;
            w_next     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = w_is_sw ? 2'b01 : 2'b00;
        w_next  = w_is_sw ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (w_timeout)       w_next = S_FETCH;
        else if (w_complete) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        w_rw      = 1'b1;
        w_next    = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        w_mw   = w_complete;
        if (w_complete || w_timeout) w_next = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA   = 2'b10;
        w_alu_sel = w_alu_dec;
        w_next    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        w_alu_sel = w_alu_dec;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_rw   = 1'b1;
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        w_alu_sel  = 3'b010;
        w_pcw      = w_take;
        illegal_op = w_bad_br;
        w_next     = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        ImmSrc  = 2'b11;
        w_pcw   = 1'b1;
        w_next  = S_ALUWB;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Enables are qualified by rst_n so nothing writes while reset is asserted.
  assign PCWrite    = w_pcw & rst_n;
  assign IRWrite    = w_irw & rst_n;
  assign MemWrite   = w_mw & rst_n;
  assign RegWrite   = w_rw & rst_n;
  assign mem_req    = w_mem_state;
  assign ALUControl = ALU_CTRL_W'(w_alu_sel);
  assign state      = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: expected per-cycle outputs queued, then compared at negedge.
module tb_multicycle_control_unit;

  localparam int ALU_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [6:0]       op = '0;
  logic [2:0]       funct3 = '0;
  logic             funct7b5 = 1'b0;
  logic             Zero = 1'b0;
  logic             SignFlag = 1'b0;
  logic             mem_ready = 1'b1;
  logic             mem_req, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite;
  logic [1:0]       ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [ALU_W-1:0] ALUControl;
  logic             illegal_op, bus_err;
  logic [3:0]       state;

  multicycle_control_unit #(.ALU_CTRL_W(ALU_W), .MEM_HANDSHAKE(1'b1), .WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .SignFlag(SignFlag), .mem_ready(mem_ready), .mem_req(mem_req),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal_op(illegal_op),
    .bus_err(bus_err), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       req, pcw, adr, irw, mw, rw;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu;
    logic       ill, berr;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    n_chk = 0;
  int    n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Per-state expected outputs, written from the state table.
  function automatic exp_t e_fetch(input logic c, input logic be);
    exp_t e = '0;
    e.st = 4'd0; e.req = 1'b1; e.pcw = c; e.irw = c; e.rs = 2'b10; e.sb = 2'b10; e.berr = be;
    return e;
  endfunction
  function automatic exp_t e_decode(input logic ill);
    exp_t e = '0;
    e.st = 4'd1; e.sa = 2'b01; e.sb = 2'b01; e.imm = 2'b10; e.ill = ill;
    return e;
  endfunction
  function automatic exp_t e_memadr(input logic sw);
    exp_t e = '0;
    e.st = 4'd2; e.sa = 2'b10; e.sb = 2'b01; e.imm = sw ? 2'b01 : 2'b00;
    return e;
  endfunction
  function automatic exp_t e_memread();
    exp_t e = '0;
    e.st = 4'd3; e.req = 1'b1; e.adr = 1'b1;
    return e;
  endfunction
  function automatic exp_t e_memwb();
    exp_t e = '0;
    e.st = 4'd4; e.rs = 2'b01; e.rw = 1'b1;
    return e;
  endfunction
  function automatic exp_t e_memwrite(input logic c);
    exp_t e = '0;
    e.st = 4'd5; e.req = 1'b1; e.adr = 1'b1; e.mw = c;
    return e;
  endfunction
  function automatic exp_t e_exec(input logic imm_form, input logic [2:0] alu);
    exp_t e = '0;
    e.st = imm_form ? 4'd7 : 4'd6; e.sa = 2'b10; e.sb = imm_form ? 2'b01 : 2'b00; e.alu = alu;
    return e;
  endfunction
  function automatic exp_t e_aluwb();
    exp_t e = '0;
    e.st = 4'd8; e.rw = 1'b1;
    return e;
  endfunction
  function automatic exp_t e_branch(input logic take, input logic ill);
    exp_t e = '0;
    e.st = 4'd9; e.sa = 2'b10; e.alu = 3'b010; e.pcw = take; e.ill = ill;
    return e;
  endfunction
  function automatic exp_t e_jal();
    exp_t e = '0;
    e.st = 4'd10; e.sa = 2'b01; e.sb = 2'b10; e.imm = 2'b11; e.pcw = 1'b1;
    return e;
  endfunction

  task automatic cmp_next();
    exp_t  e;
    string t;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard: queue empty when output sampled");
      return;
    end
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    chk({t, ".state"},  32'(state),      32'(e.st));
    chk({t, ".req"},    32'(mem_req),    32'(e.req));
    chk({t, ".pcw"},    32'(PCWrite),    32'(e.pcw));
    chk({t, ".adr"},    32'(AdrSrc),     32'(e.adr));
    chk({t, ".irw"},    32'(IRWrite),    32'(e.irw));
    chk({t, ".mw"},     32'(MemWrite),   32'(e.mw));
    chk({t, ".rw"},     32'(RegWrite),   32'(e.rw));
    chk({t, ".rs"},     32'(ResultSrc),  32'(e.rs));
    chk({t, ".sa"},     32'(ALUSrcA),    32'(e.sa));
    chk({t, ".sb"},     32'(ALUSrcB),    32'(e.sb));
    chk({t, ".imm"},    32'(ImmSrc),     32'(e.imm));
    chk({t, ".alu"},    32'(ALUControl), 32'(e.alu));
    chk({t, ".ill"},    32'(illegal_op), 32'(e.ill));
    chk({t, ".berr"},   32'(bus_err),    32'(e.berr));
  endtask

  task automatic step(input string tag, input exp_t e, input logic rdy,
                      input logic z = 1'b0, input logic s = 1'b0);
    mem_ready = rdy;
    Zero      = z;
    SignFlag  = s;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    cmp_next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o; funct3 = f3; funct7b5 = f7;
  endtask

  task automatic run_lw(input string tag);
    set_instr(7'b0000011, 3'b010, 1'b0);
    step({tag, ".F"},  e_fetch(1'b1, 1'b0), 1'b1);
    step({tag, ".D"},  e_decode(1'b0),      1'b1);
    step({tag, ".MA"}, e_memadr(1'b0),      1'b1);
    step({tag, ".MR"}, e_memread(),         1'b1);
    step({tag, ".WB"}, e_memwb(),           1'b1);
  endtask

  task automatic run_alu(input string tag, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic [2:0] alu);
    set_instr(o, f3, f7);
    step({tag, ".F"},  e_fetch(1'b1, 1'b0),   1'b1);
    step({tag, ".D"},  e_decode(1'b0),        1'b1);
    step({tag, ".EX"}, e_exec(o[5] == 1'b0, alu), 1'b1);
    step({tag, ".WB"}, e_aluwb(),             1'b1);
  endtask

  task automatic run_br(input string tag, input logic [2:0] f3, input logic z,
                        input logic s, input logic take, input logic ill);
    set_instr(7'b1100011, f3, 1'b0);
    step({tag, ".F"},  e_fetch(1'b1, 1'b0), 1'b1);
    step({tag, ".D"},  e_decode(1'b0),      1'b1);
    step({tag, ".BR"}, e_branch(take, ill), 1'b1, z, s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held in FETCH with mem_ready=1: enables must stay low.
    sb_q.push_back(e_fetch(1'b0, 1'b0));
    tag_q.push_back("rst");
    @(negedge clk);
    cmp_next();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_lw("lw");

    set_instr(7'b0000011, 3'b010, 1'b0);
    step("lwwait.F",   e_fetch(1'b1, 1'b0), 1'b1);
    step("lwwait.D",   e_decode(1'b0),      1'b1);
    step("lwwait.MA",  e_memadr(1'b0),      1'b1);
    step("lwwait.MR0", e_memread(),         1'b0);
    step("lwwait.MR1", e_memread(),         1'b1);
    step("lwwait.WB",  e_memwb(),           1'b1);

    run_alu("sub",  7'b0110011, 3'b000, 1'b1, 3'b010);
    run_alu("srl",  7'b0110011, 3'b101, 1'b0, 3'b101);
    run_alu("and",  7'b0110011, 3'b111, 1'b0, 3'b111);
    run_alu("srai", 7'b0010011, 3'b101, 1'b1, 3'b011);
    run_alu("addi", 7'b0010011, 3'b000, 1'b1, 3'b000);
    run_alu("slli", 7'b0010011, 3'b001, 1'b0, 3'b001);

    run_br("bge_t",  3'b101, 1'b0, 1'b0, 1'b1, 1'b0);
    run_br("bge_nt", 3'b101, 1'b0, 1'b1, 1'b0, 1'b0);
    run_br("beq_t",  3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
    run_br("bne_nt", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
    run_br("blt_t",  3'b100, 1'b0, 1'b1, 1'b1, 1'b0);
    run_br("bbad",   3'b010, 1'b1, 1'b1, 1'b0, 1'b1);

    set_instr(7'b1101111, 3'b000, 1'b0);
    step("jal.F",  e_fetch(1'b1, 1'b0), 1'b1);
    step("jal.D",  e_decode(1'b0),      1'b1);
    step("jal.J",  e_jal(),             1'b1);
    step("jal.WB", e_aluwb(),           1'b1);

    set_instr(7'b0100011, 3'b010, 1'b0);
    step("sw.F",   e_fetch(1'b1, 1'b0), 1'b1);
    step("sw.D",   e_decode(1'b0),      1'b1);
    step("sw.MA",  e_memadr(1'b1),      1'b1);
    step("sw.MW0", e_memwrite(1'b0),    1'b0);
    step("sw.MW1", e_memwrite(1'b0),    1'b0);
    step("sw.MW2", e_memwrite(1'b1),    1'b1);

    set_instr(7'b1111111, 3'b000, 1'b0);
    step("ill.F", e_fetch(1'b1, 1'b0), 1'b1);
    step("ill.D", e_decode(1'b1),      1'b1);

    for (int i = 0; i < 15; i++) step("to.wait", e_fetch(1'b0, 1'b0), 1'b0);
    step("to.err", e_fetch(1'b0, 1'b1), 1'b0);

    // Reset asserted mid-MEMWB: the write enable must drop at once.
    set_instr(7'b0000011, 3'b010, 1'b0);
    step("rstwb.F",  e_fetch(1'b1, 1'b0), 1'b1);
    step("rstwb.D",  e_decode(1'b0),      1'b1);
    step("rstwb.MA", e_memadr(1'b0),      1'b1);
    step("rstwb.MR", e_memread(),         1'b1);
    #2;
    chk("rstwb.rw_before", 32'(RegWrite), 32'd1);
    rst_n = 1'b0;
    #1;
    sb_q.push_back(e_fetch(1'b0, 1'b0));
    tag_q.push_back("rstwb.async");
    cmp_next();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_lw("lw_after");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
